// File: rtl/mem_lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
// Latency: none, declarations only. Backpressure: not applicable.
package mem_lsu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam logic [DATA_WIDTH-1:0] ZERO = '0;
    localparam logic WRITE_DISABLE = 1'b0;

    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LH  = 4'd2,
        MEM_LW  = 4'd3,
        MEM_LBU = 4'd4,
        MEM_LHU = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_DONE
    } lsu_state_e;

    typedef struct packed {
        logic                  we;
        logic [DATA_WIDTH-1:0] addr;
        logic [3:0]            be;
        logic [DATA_WIDTH-1:0] wdata;
    } bus_req_t;

    function automatic logic is_load(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: is_load = 1'b1;
            default:                                  is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        case (op)
            MEM_SB, MEM_SH, MEM_SW: is_store = 1'b1;
            default:                is_store = 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: is_misaligned = a[0];
            MEM_LW, MEM_SW:          is_misaligned = |a;
            default:                 is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// req/gnt/rvalid data bus between the load/store unit and memory.
// Latency: wires only. Backpressure: gnt holds off a request, rvalid follows gnt.
interface mem_lsu_if;
    import mem_lsu_pkg::*;

    logic                  req;
    logic                  we;
    logic [DATA_WIDTH-1:0] addr;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_lsu_align.sv
// Byte-enable / store-lane replication and load lane extraction with extension.
// Latency: combinational. Backpressure: none.
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [3:0]            op,
    input  logic [1:0]            addr_lo,
    input  logic [DATA_WIDTH-1:0] st_data,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [3:0]            be,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] ld_data
);

    logic [DATA_WIDTH-1:0] lane;

    always_comb begin
        be    = 4'b0000;
        wdata = ZERO;
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            MEM_LH, MEM_LHU, MEM_SH: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{st_data[15:0]}};
            end
            MEM_LW, MEM_SW: begin
                be    = 4'b1111;
                wdata = st_data;
            end
            default: ;
        endcase
    end

    // Move the addressed byte/half down to bit 0 before extending.
    assign lane = rdata >> {addr_lo, 3'b000};

    always_comb begin
        ld_data = ZERO;
        case (op)
            MEM_LB:  ld_data = {{24{lane[7]}}, lane[7:0]};
            MEM_LBU: ld_data = {24'h0, lane[7:0]};
            MEM_LH:  ld_data = {{16{lane[15]}}, lane[15:0]};
            MEM_LHU: ld_data = {16'h0, lane[15:0]};
            MEM_LW:  ld_data = rdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: runs one exe_mem access on the data bus, returns extended load data.
// Latency: store >=2 stall cycles, load >=3; each gnt/rvalid wait cycle adds one. Backpressure: stallreq_o freezes the pipe.
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [4:0]            reg_waddr_i,
    input  logic                  reg_we_i,
    input  logic [DATA_WIDTH-1:0] reg_wdata_i,
    input  logic                  mem_we_i,
    input  logic [DATA_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic [3:0]            mem_op_i,
    mem_lsu_if.master             dbus,
    output logic [4:0]            reg_waddr_o,
    output logic                  reg_we_o,
    output logic [DATA_WIDTH-1:0] reg_wdata_o,
    output logic                  stallreq_o,
    output logic                  misalign_o
);

    lsu_state_e            state_q, state_d;
    bus_req_t              bus_q;
    logic                  req_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  mem_vld;
    logic                  active;
    logic                  capture;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  unused_mem_we;

    // The op code alone decides direction; the store flag is redundant.
    assign unused_mem_we = mem_we_i;

    assign mem_vld    = is_load(mem_op_i) | is_store(mem_op_i);
    assign misalign_o = mem_vld & is_misaligned(mem_op_i, mem_addr_i[1:0]);
    assign active     = mem_vld & ~misalign_o;

    mem_lsu_align u_align (
        .op      (mem_op_i),
        .addr_lo (mem_addr_i[1:0]),
        .st_data (mem_data_i),
        .rdata   (dbus.rdata),
        .be      (be),
        .wdata   (wdata),
        .ld_data (ld_data)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (active)      state_d = ST_REQ;
            ST_REQ:  if (dbus.gnt)    state_d = bus_q.we ? ST_DONE : ST_RESP;
            ST_RESP: if (dbus.rvalid) state_d = ST_DONE;
            ST_DONE:                  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stallreq_o  = active && (state_q != ST_DONE);
        capture     = active && (state_q == ST_IDLE);
        reg_waddr_o = reg_waddr_i;
        reg_we_o    = reg_we_i;
        reg_wdata_o = reg_wdata_i;
        if (mem_vld) begin
            reg_we_o    = WRITE_DISABLE;
            reg_wdata_o = ZERO;
            // Load data is only released in the cycle the pipeline advances.
            if (active && is_load(mem_op_i) && (state_q == ST_DONE)) begin
                reg_we_o    = reg_we_i;
                reg_wdata_o = rdata_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bus_q   <= '0;
            req_q   <= 1'b0;
            rdata_q <= ZERO;
        end else begin
            if (capture) begin
                bus_q <= '{we:    is_store(mem_op_i),
                           addr:  {mem_addr_i[DATA_WIDTH-1:2], 2'b00},
                           be:    be,
                           wdata: wdata};
            end
            req_q <= (state_d == ST_REQ);
            if ((state_q == ST_RESP) && dbus.rvalid) begin
                rdata_q <= ld_data;
            end
        end
    end

    assign dbus.req   = req_q;
    assign dbus.we    = bus_q.we;
    assign dbus.addr  = bus_q.addr;
    assign dbus.be    = bus_q.be;
    assign dbus.wdata = bus_q.wdata;

endmodule

// File: tb/tb_mem_lsu.sv
// Randomised + directed bench for mem_lsu: byte-level memory model, bus and writeback scoreboards.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [4:0]  reg_waddr_i;
    logic        reg_we_i;
    logic [31:0] reg_wdata_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [3:0]  mem_op_i;
    logic [4:0]  reg_waddr_o;
    logic        reg_we_o;
    logic [31:0] reg_wdata_o;
    logic        stallreq_o;
    logic        misalign_o;

    mem_lsu_if dbus ();

    mem_lsu dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .reg_waddr_i (reg_waddr_i),
        .reg_we_i    (reg_we_i),
        .reg_wdata_i (reg_wdata_i),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_data_i  (mem_data_i),
        .mem_op_i    (mem_op_i),
        .dbus        (dbus),
        .reg_waddr_o (reg_waddr_o),
        .reg_we_o    (reg_we_o),
        .reg_wdata_o (reg_wdata_o),
        .stallreq_o  (stallreq_o),
        .misalign_o  (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic [4:0]  waddr;
        logic        we;
        logic        chk_data;
        logic [31:0] wdata;
    } wb_exp_t;

    bus_exp_t    bus_q[$];
    wb_exp_t     wb_q[$];
    logic [7:0]  mb[0:1023];
    logic [31:0] dev[0:255];
    int          gnt_dly = 0;
    int          rv_dly = 0;
    bit          inject_rv = 1'b0;
    bit          bail = 1'b0;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int size_of(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 1;
            MEM_LH, MEM_LHU, MEM_SH: return 2;
            MEM_LW, MEM_SW:          return 4;
            default:                 return 0;
        endcase
    endfunction

    function automatic bit is_ld(input logic [3:0] op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) || (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    // Bus request as seen from the memory: word address, touched lanes, store bytes repeated across lanes.
    function automatic bus_exp_t make_bus(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data);
        bus_exp_t b;
        int sz = size_of(op);
        int a = int'(addr[1:0]);
        b.we    = !is_ld(op);
        b.addr  = {addr[31:2], 2'b00};
        b.be    = '0;
        b.wdata = '0;
        for (int i = 0; i < 4; i++) begin
            b.wdata[8*i +: 8] = data[8*(i % sz) +: 8];
            if (i >= a && i < a + sz) b.be[i] = 1'b1;
        end
        return b;
    endfunction

    task automatic set_word(input logic [31:0] addr, input logic [31:0] val);
        dev[addr[9:2]] = val;
        for (int i = 0; i < 4; i++) mb[int'({addr[9:2], 2'b00}) + i] = val[8*i +: 8];
    endtask

    // Called just after a rising edge; leaves just after the rising edge at which the op retires.
    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input int gd, input int rd);
        int      sz;
        bit      ld, mis, ok;
        int      stall, exp_stall;
        wb_exp_t w;
        logic [31:0] v;
        if (bail) return;
        sz  = size_of(op);
        ld  = is_ld(op);
        mis = (sz > 1) && ((int'(addr[1:0]) % sz) != 0);
        gnt_dly = gd;
        rv_dly  = rd;
        mem_op_i    = op;
        mem_addr_i  = addr;
        mem_data_i  = data;
        mem_we_i    = (sz > 0) && !ld;
        reg_waddr_i = 5'($urandom);
        reg_we_i    = 1'($urandom);
        reg_wdata_i = $urandom;
        w.waddr = reg_waddr_i;
        if (sz == 0) begin
            w.we = reg_we_i; w.chk_data = 1'b1; w.wdata = reg_wdata_i;
        end else if (mis || !ld) begin
            w.we = 1'b0; w.chk_data = 1'b0; w.wdata = '0;
        end else begin
            v = '0;
            for (int i = 0; i < sz; i++) v[8*i +: 8] = mb[int'(addr[9:0]) + i];
            if (op == MEM_LB && v[7])  v[31:8]  = '1;
            if (op == MEM_LH && v[15]) v[31:16] = '1;
            w.we = reg_we_i; w.chk_data = 1'b1; w.wdata = v;
        end
        wb_q.push_back(w);
        if (sz > 0 && !mis) begin
            bus_q.push_back(make_bus(op, addr, data));
            if (!ld) for (int i = 0; i < sz; i++) mb[int'(addr[9:0]) + i] = data[8*i +: 8];
        end
        if (sz == 0 || mis) exp_stall = 0;
        else if (!ld)       exp_stall = 2 + gd;
        else                exp_stall = 3 + gd + rd;
        stall = 0;
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_i);
            if (c == 0) check("misalign", 32'(misalign_o), 32'(mis));
            if (!stallreq_o) begin ok = 1'b1; break; end
            stall++;
        end
        if (!ok) begin
            failures++;
            $display("FAIL stall_timeout: op %0d still stalled after 60 cycles, expected %0d", op, exp_stall);
            bail = 1'b1;
        end else begin
            check("stall_cycles", 32'(stall), 32'(exp_stall));
        end
        @(posedge clk_i); #1;
    endtask

    // Memory slave: word array written through be, read with configurable gnt/rvalid delays.
    initial begin
        int gc = 0;
        int rc = 0;
        bit pend = 1'b0;
        logic [31:0] pd = '0;
        dbus.gnt = 1'b0; dbus.rvalid = 1'b0; dbus.rdata = '0;
        forever begin
            @(posedge clk_i); #1;
            dbus.gnt = 1'b0; dbus.rvalid = 1'b0; dbus.rdata = $urandom;
            if (!rst_n_i) begin
                pend = 1'b0; gc = 0;
            end else if (inject_rv) begin
                dbus.rvalid = 1'b1; inject_rv = 1'b0;
            end else if (pend) begin
                if (rc >= rv_dly) begin dbus.rvalid = 1'b1; dbus.rdata = pd; pend = 1'b0; end
                else rc++;
            end else if (dbus.req) begin
                if (gc >= gnt_dly) begin
                    dbus.gnt = 1'b1; gc = 0;
                    if (dbus.we) begin
                        for (int i = 0; i < 4; i++)
                            if (dbus.be[i]) dev[dbus.addr[9:2]][8*i +: 8] = dbus.wdata[8*i +: 8];
                    end else begin
                        pend = 1'b1; rc = 0; pd = dev[dbus.addr[9:2]];
                    end
                end else gc++;
            end
        end
    end

    // Bus monitor: every granted request must match the oldest expected one.
    initial begin
        bit prev_gnt = 1'b0;
        bus_exp_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_n_i) begin prev_gnt = 1'b0; continue; end
            if (prev_gnt) check("req_after_gnt", 32'(dbus.req), 32'd0);
            if (dbus.req && dbus.gnt) begin
                if (bus_q.size() == 0) begin
                    failures++; checks++;
                    $display("FAIL unexpected_req: addr 0x%08h we %0d, expected no request", dbus.addr, dbus.we);
                end else begin
                    e = bus_q.pop_front();
                    check("bus_we",    32'(dbus.we), 32'(e.we));
                    check("bus_addr",  dbus.addr,    e.addr);
                    check("bus_be",    32'(dbus.be), 32'(e.be));
                    if (e.we) check("bus_wdata", dbus.wdata, e.wdata);
                end
            end
            prev_gnt = dbus.req && dbus.gnt;
        end
    end

    // Writeback monitor: each non-stalled cycle retires the op in exe_mem.
    initial begin
        wb_exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_n_i && !stallreq_o && wb_q.size() > 0) begin
                e = wb_q.pop_front();
                check("wb_waddr", 32'(reg_waddr_o), 32'(e.waddr));
                check("wb_we",    32'(reg_we_o),    32'(e.we));
                if (e.chk_data) check("wb_wdata", reg_wdata_o, e.wdata);
            end
        end
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] addr;
        bit ok;
        mem_op_i = MEM_NOP; mem_addr_i = '0; mem_data_i = '0; mem_we_i = 1'b0;
        reg_waddr_i = '0; reg_we_i = 1'b0; reg_wdata_i = '0;
        for (int i = 0; i < 256; i++) set_word(32'(i * 4), $urandom);
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_req",   32'(dbus.req),  32'd0);
        check("rst_we",    32'(dbus.we),   32'd0);
        check("rst_addr",  dbus.addr,      32'd0);
        check("rst_be",    32'(dbus.be),   32'd0);
        check("rst_wdata", dbus.wdata,     32'd0);
        check("rst_stall", 32'(stallreq_o), 32'd0);
        @(negedge clk_i) rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        issue(MEM_SW, 32'h100, 32'hDEADBEEF, 0, 0);
        set_word(32'h200, 32'h80FF_FFFF);
        issue(MEM_LB, 32'h203, 32'h0, 0, 0);
        set_word(32'h300, 32'h8001_1234);
        issue(MEM_LHU, 32'h302, 32'h0, 3, 0);
        issue(MEM_SB, 32'h001, 32'h0000_00AB, 0, 0);
        issue(MEM_LW, 32'h001, 32'h0, 0, 0);
        issue(MEM_LW, 32'h102, 32'h0, 0, 0);
        issue(MEM_NOP, 32'h104, 32'h1234, 0, 0);
        issue(4'd12, 32'h108, 32'h5678, 0, 0);
        issue(MEM_LH, 32'h100, 32'h0, 1, 2);

        for (int n = 0; n < 250; n++) begin
            op   = 4'($urandom_range(0, 15));
            addr = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) addr = {addr[31:2], 2'b00} | 32'(2 * $urandom_range(0, 1) * int'(op == MEM_LH || op == MEM_LHU || op == MEM_SH));
            issue(op, addr, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        if (!bail) begin
            // Reset while waiting for gnt: req must fall without a clock edge.
            gnt_dly = 20; rv_dly = 0;
            mem_op_i = MEM_LW; mem_addr_i = 32'h40;
            repeat (3) @(negedge clk_i);
            check("req_before_rst", 32'(dbus.req), 32'd1);
            #2 rst_n_i = 1'b0;
            #1 check("req_async_drop", 32'(dbus.req), 32'd0);
            mem_op_i = MEM_NOP;
            @(negedge clk_i) rst_n_i = 1'b1;
            @(posedge clk_i); #1;

            // Reset while in RESP: the late rvalid must be ignored.
            gnt_dly = 0; rv_dly = 30;
            mem_op_i = MEM_LW; mem_addr_i = 32'h80;
            bus_q.push_back(make_bus(MEM_LW, 32'h80, 32'h0));
            ok = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk_i);
                if (dbus.req && dbus.gnt) begin ok = 1'b1; break; end
            end
            if (!ok) begin
                failures++;
                $display("FAIL gnt_timeout: no grant within 20 cycles, expected one");
            end
            @(negedge clk_i);
            check("stall_in_resp", 32'(stallreq_o), 32'd1);
            #2 rst_n_i = 1'b0;
            #1 check("req_rst_resp", 32'(dbus.req), 32'd0);
            mem_op_i = MEM_NOP;
            #1 check("stall_in_rst", 32'(stallreq_o), 32'd0);
            @(negedge clk_i) rst_n_i = 1'b1;
            inject_rv = 1'b1;
            rv_dly = 0;
            repeat (2) @(posedge clk_i);
            #1;
            set_word(32'h80, 32'hCAFE_F00D);
            issue(MEM_LW, 32'h80, 32'h0, 0, 0);
            issue(MEM_LBU, 32'h83, 32'h0, 1, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit for the MEM stage of the 5-stage RISC-V core. Consumes the memory request the execute stage places in exe_mem (`mem_we`, `mem_addr`, `mem_data`, `mem_op`), runs it on a req/gnt/rvalid data bus, and returns aligned, extended load data to mem_wb. It raises `stallreq_o` to pipe_ctrl while a bus transaction is outstanding. Non-memory instructions pass straight through.

## Interface
- DATA_WIDTH, 32, datapath width; only 32 is supported.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- reg_waddr_i / reg_we_i / reg_wdata_i  in  5/1/32  writeback request from exe_mem.
- mem_we_i  in  1  store flag from exe_mem; informational only, `mem_op_i` is authoritative.
- mem_addr_i  in  32  byte address.
- mem_data_i  in  32  store data, right-justified.
- mem_op_i  in  4  `MEM_*` code.
- dbus_req_o  out  1  bus request, registered.
- dbus_we_o  out  1  1 = write.
- dbus_addr_o  out  32  word address, bits [1:0] = 0.
- dbus_be_o  out  4  byte enables.
- dbus_wdata_o  out  32  lane-replicated store data.
- dbus_gnt_i  in  1  request accepted this cycle.
- dbus_rvalid_i / dbus_rdata_i  in  1/32  read response; arrives ≥1 cycle after gnt.
- reg_waddr_o / reg_we_o / reg_wdata_o  out  5/1/32  to mem_wb.
- stallreq_o  out  1  to pipe_ctrl.
- misalign_o  out  1  misaligned access flag, combinational.

## Operation
- **Encoding (defines.v):**
  - `MEM_NOP`=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8.
  - Codes 9–15 are treated as NOP.
- **Non-memory op (NOP):**
  - `reg_*_o` = `reg_*_i` combinationally.
  - `stallreq_o`=0; no bus activity.
- **Misalignment:**
  - Misaligned when: (LH/LHU/SH and addr[0]) or (LW/SW and addr[1:0]≠0).
  - Then `misalign_o`=1, no bus access, `reg_we_o`=0, `stallreq_o`=0.
- **Byte enables / write data** (a = addr[1:0]):
  - Byte ops: be = 1<<a; wdata = {4{data[7:0]}}.
  - Half ops: be = a[1] ? 1100 : 0011; wdata = {2{data[15:0]}}.
  - Word ops: be = 1111; wdata = data.
  - Loads drive the same be with `dbus_we_o`=0.
- **Load extract:**
  - lane = rdata >> (8·a).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- **FSM:**
  - IDLE: on a valid aligned memory op, capture addr/be/wdata/we into flops → REQ.
  - REQ: `dbus_req_o`=1, bus outputs held stable. On gnt: store → DONE, load → RESP.
  - RESP: wait for rvalid; register the extended data in `rdata_q` → DONE.
  - DONE: `req`=0 → IDLE.
- **Stall rule:** `stallreq_o` = valid aligned memory op && state≠DONE (combinational). In DONE the pipeline advances at that clock edge.
- **Input stability:** pipe_ctrl freezes exe_mem while stalled, so `mem_*_i` are stable from IDLE through DONE.
- **Writeback during a load:**
  - `reg_we_o`=0 and `reg_wdata_o`=0 until DONE.
  - In DONE: `reg_wdata_o` = `rdata_q`, `reg_we_o` = `reg_we_i`.
- **Writeback for stores:** `reg_we_o`=0 throughout.
- **Late response:** rvalid in a state other than RESP is ignored.

## Timing
- **Reset values:**
  - state=IDLE; `dbus_req_o`=0, `dbus_we_o`=0, `dbus_addr_o`=0, `dbus_be_o`=0, `dbus_wdata_o`=0; `rdata_q`=0.
  - Combinational outputs follow their inputs.
- **Minimum stall:**
  - Store: 2 cycles (IDLE, REQ with gnt).
  - Load: 3 cycles (IDLE, REQ with gnt, RESP with rvalid).
  - Each cycle of gnt or rvalid delay adds one stall cycle.
- **Back-to-back ops:** DONE→IDLE costs one cycle. The next op is sampled in IDLE of the following cycle, so the bus is never requested two cycles running.
- **Reset mid-transaction:** returns to IDLE immediately. `dbus_req_o` drops asynchronously and the in-flight response is discarded.

## Structure
- `MEM_*` codes, `DATA_WIDTH`, `ZERO`, and `WRITE_DISABLE` live in defines.v, shared with exe.
- Sub-module `mem_lsu_align` (combinational): computes be/wdata from (op, addr, data) and load extraction from (op, addr, rdata). Instantiated once.
- The FSM and its flops sit in `mem_lsu`.

## Test plan
- **SW aligned:** SW addr 0x100, data 0xDEADBEEF, gnt on first REQ cycle → be=1111, addr=0x100, we=1; stall high 2 cycles; `reg_we_o`=0.
- **LB sign-extend:** LB addr 0x203, rdata 0x80FF_FFFF one cycle after gnt → `reg_wdata_o`=0xFFFF_FF80 in DONE, be=1000, stall 3 cycles.
- **LHU with delayed gnt:** LHU addr 0x302, rdata 0x8001_1234, gnt delayed 3 cycles → `reg_wdata_o`=0x0000_8001, stall 6 cycles.
- **SB lane replication:** SB addr 0x1, data 0x0000_00AB → wdata=0xABAB_ABAB, be=0010.
- **Misaligned:** LW addr 0x102 → `misalign_o`=1, `dbus_req_o` never asserted, `stallreq_o`=0, `reg_we_o`=0. NOP/ALU op → passthrough, no stall.
- **Reset mid-transaction:** `rst_n_i` low while in RESP → `dbus_req_o`=0 and state IDLE immediately. An rvalid after release is ignored and the next LW completes normally.
